// File: rtl/icap_ctrl_pkg.sv
// Shared definitions for the ICAP master controller: FSM state encoding and
// ICAP control-pin polarities.
package icap_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TURN_R = 3'd1,
    READ   = 3'd2,
    DRAIN  = 3'd3,
    TURN_W = 3'd4
  } state_t;

  // ICAP CE is active-low; WRITE pin high selects readback.
  localparam logic ICAP_CE_ON  = 1'b0;
  localparam logic ICAP_DIR_RD = 1'b1;
  localparam logic ICAP_DIR_WR = 1'b0;

endpackage

// File: rtl/icap_bitswap.sv
// Combinational bit reversal within each byte of a word, matching the
// Virtex-5 ICAP bit ordering. Bits beyond the last whole byte are driven 0.
module icap_bitswap #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] swapped
);

  // Mirror bit k of each byte onto bit 7-k of the same byte.
  always_comb begin
    swapped = '0;
    for (int unsigned b = 0; b < WIDTH / 8; b++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        swapped[8*b + k] = word[8*b + 7 - k];
      end
    end
  end

endmodule

// File: rtl/icap_master_ctrl.sv
// Initiator side of the ICAP port: streams bitstream words into ICAP through
// a one-word hold register and performs counted readback bursts.
// Optional build macro: ICAP_BITSWAP_EN (per-byte bit reversal on I and O).
module icap_master_ctrl
  import icap_ctrl_pkg::*;
#(
  parameter int unsigned ICAP_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic        IS_BUSY    = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ICAP_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [CNT_WIDTH-1:0]  rd_len,
  output logic [ICAP_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_done,
  output logic                  ctrl_busy,
  output logic                  icap_ce,
  output logic                  icap_write,
  output logic [ICAP_WIDTH-1:0] icap_i,
  input  logic [ICAP_WIDTH-1:0] icap_o,
  input  logic                  icap_busy
);

  state_t                state, state_nxt;
  logic [ICAP_WIDTH-1:0] word, word_nxt;
  logic [ICAP_WIDTH-1:0] rd_word;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  held, held_nxt;
  logic                  rd_pend, pend_nxt;
  logic                  cap, cap_nxt;
  logic                  ce_nxt, write_nxt, done_nxt;
  logic                  accept, ready_int, wr_fire, rd_take;

  // An ICAP transfer completes on any edge where CE is asserted and BUSY is not stalling.
  assign accept    = (icap_ce == ICAP_CE_ON) && (icap_busy != IS_BUSY);
  assign ctrl_busy = (state != IDLE) || held;
  assign ready_int = (state == IDLE) && !rd_pend && (!held || accept);
  assign wr_fire   = wr_valid && ready_int;
  assign rd_take   = rd_req && !ctrl_busy && !rd_pend;
  // Internal handshake excludes RESET so the reset net only feeds flop resets.
  assign wr_ready  = ready_int && !RESET;

`ifdef ICAP_BITSWAP_EN
  icap_bitswap #(.WIDTH(ICAP_WIDTH)) u_swap_wr (
    .word    (word),
    .swapped (icap_i)
  );
  icap_bitswap #(.WIDTH(ICAP_WIDTH)) u_swap_rd (
    .word    (icap_o),
    .swapped (rd_word)
  );
`else
  assign icap_i  = word;
  assign rd_word = icap_o;
`endif

  // Control state and registered ICAP pins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      icap_ce    <= ~ICAP_CE_ON;
      icap_write <= ICAP_DIR_WR;
      word       <= '0;
      held       <= 1'b0;
      rd_pend    <= 1'b0;
      cnt        <= '0;
      cap        <= 1'b0;
      rd_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      icap_ce    <= ce_nxt;
      icap_write <= write_nxt;
      word       <= word_nxt;
      held       <= held_nxt;
      rd_pend    <= pend_nxt;
      cnt        <= cnt_nxt;
      cap        <= cap_nxt;
      rd_done    <= done_nxt;
    end
  end

  // Next-state and next-output decode; WRITE only changes while CE is
  // deasserted (entering TURN_R, leaving TURN_W) so the two never move together.
  always_comb begin
    state_nxt = state;
    ce_nxt    = icap_ce;
    write_nxt = icap_write;
    word_nxt  = word;
    held_nxt  = held;
    pend_nxt  = rd_pend;
    cnt_nxt   = cnt;
    cap_nxt   = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_fire) begin
          word_nxt = wr_data;
          ce_nxt   = ICAP_CE_ON;
          held_nxt = 1'b1;
        end else if (accept) begin
          ce_nxt   = ~ICAP_CE_ON;
          held_nxt = 1'b0;
        end
        if (rd_take) begin
          if (rd_len != '0) begin
            pend_nxt = 1'b1;
            cnt_nxt  = rd_len;
          end else begin
            done_nxt = 1'b1;
          end
        end
        if (rd_pend && !held) begin
          state_nxt = TURN_R;
          pend_nxt  = 1'b0;
          write_nxt = ICAP_DIR_RD;
        end
      end
      TURN_R: begin
        ce_nxt    = ICAP_CE_ON;
        state_nxt = READ;
      end
      READ: begin
        if (accept) begin
          cap_nxt = 1'b1;
          cnt_nxt = cnt - CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(1)) begin
            ce_nxt    = ~ICAP_CE_ON;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cap) begin
          done_nxt  = 1'b1;
          state_nxt = TURN_W;
        end
      end
      TURN_W: begin
        write_nxt = ICAP_DIR_WR;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Readback capture: word accepted on edge N is taken from O on edge N+1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= cap;
      if (cap) begin
        rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_icap_master_ctrl.sv
// Directed bench for icap_master_ctrl with a small behavioural ICAP model.
// Honours ICAP_BITSWAP_EN when defined.
module tb_icap_master_ctrl;

  localparam logic IS_BUSY = 1'b0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        rd_req;
  logic [15:0] rd_len;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_done;
  logic        ctrl_busy;
  logic        icap_ce;
  logic        icap_write;
  logic [31:0] icap_i;
  logic [31:0] icap_o;
  logic        icap_busy;

  int n_checks = 0;
  int n_errors = 0;

  icap_master_ctrl #(
    .ICAP_WIDTH (32),
    .CNT_WIDTH  (16),
    .IS_BUSY    (IS_BUSY)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_req     (rd_req),
    .rd_len     (rd_len),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_done    (rd_done),
    .ctrl_busy  (ctrl_busy),
    .icap_ce    (icap_ce),
    .icap_write (icap_write),
    .icap_i     (icap_i),
    .icap_o     (icap_o),
    .icap_busy  (icap_busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural ICAP: writes go to mem[wptr], reads return mem[rptr] on O after the edge.
  logic [31:0] mem [256];
  logic [7:0]  wptr = '0;
  logic [7:0]  rptr = '0;
  logic        model_clr = 1'b0;

  always @(posedge CLK) begin
    if (model_clr) begin
      wptr <= '0;
      rptr <= '0;
    end else if (!icap_ce && icap_busy != IS_BUSY) begin
      if (!icap_write) begin
        mem[wptr] <= icap_i;
        wptr      <= wptr + 8'd1;
      end else begin
        icap_o <= mem[rptr];
        rptr   <= rptr + 8'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word as stored by ICAP for a given bitstream word.
  function automatic logic [31:0] exp_w(input logic [31:0] x);
    logic [31:0] r;
    r = x;
`ifdef ICAP_BITSWAP_EN
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b + k] = x[8*b + 7 - k];
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    model_clr = 1'b1;
    step();
    model_clr = 1'b0;
  endtask

  int          k, cyc, viol, strobes, turn_r, done_seen, done_at, bad;
  logic        took, stall_held, pre_ce, done_valid, done_write;
  logic [31:0] pre_i;
  logic [31:0] rd_log [16];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; wr_data = '0; wr_valid = 1'b0; rd_req = 1'b0; rd_len = '0;
    icap_busy = ~IS_BUSY; icap_o = '0;
    #3;
    check("rst_ce", icap_ce, 1'b1);
    check("rst_write", icap_write, 1'b0);
    check("rst_i", icap_i, 32'h0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_done", rd_done, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_ctrl_busy", ctrl_busy, 1'b0);
    step(); step();
    RESET = 1'b0;
    step();
    model_clear();

    // 1: back-to-back stream, never stalled
    bad = 0;
    for (int w = 1; w <= 16; w++) begin
      wr_data = w; wr_valid = 1'b1;
      #1;
      if (!wr_ready) bad++;
      @(posedge CLK); #1;
    end
    wr_valid = 1'b0;
    check("t1_ready_low_cycles", bad, 0);
    check("t1_wptr_before_last", wptr, 8'd15);
    step();
    check("t1_wptr_last", wptr, 8'd16);
    check("t1_ce_idle", icap_ce, 1'b1);
    check("t1_busy_idle", ctrl_busy, 1'b0);

    // 2: same words with ~20% BUSY stall
    model_clear();
    k = 1; viol = 0; cyc = 0;
    while ((k <= 16 || wptr != 8'd16) && cyc < 400) begin
      icap_busy = ($urandom_range(0, 4) == 0) ? IS_BUSY : ~IS_BUSY;
      wr_valid  = (k <= 16);
      wr_data   = k;
      #6;
      took       = wr_valid && wr_ready;
      stall_held = !icap_ce && (icap_busy == IS_BUSY);
      pre_i      = icap_i;
      pre_ce     = icap_ce;
      step();
      if (stall_held && (icap_i !== pre_i || icap_ce !== pre_ce)) viol++;
      if (took) k++;
      cyc++;
    end
    icap_busy = ~IS_BUSY; wr_valid = 1'b0;
    check("t2_words_written", wptr, 8'd16);
    check("t2_stall_hold_violations", viol, 0);
    for (int w = 0; w < 16; w++) check($sformatf("t2_mem%0d", w), mem[w], exp_w(w + 1));
    check("t2_ce_idle", icap_ce, 1'b1);

    // 3: readback of 16 words
    model_clear();
    rd_req = 1'b1; rd_len = 16'd16;
    step();
    rd_req = 1'b0;
    strobes = 0; turn_r = 0; done_seen = 0; done_at = 0; done_valid = 0; done_write = 0;
    for (int c = 0; c < 100 && done_seen == 0; c++) begin
      if (icap_write && icap_ce && rptr == 8'd0) turn_r++;
      if (rd_valid) begin
        if (strobes == 0) check("t3_first_latency_rptr", rptr, 8'd2);
        if (strobes < 16) rd_log[strobes] = rd_data;
        strobes++;
      end
      if (rd_done) begin
        done_seen  = 1;
        done_at    = strobes;
        done_valid = rd_valid;
        done_write = icap_write;
      end
      rd_req = (strobes == 5);
      rd_len = 16'd3;
      if (done_seen == 0) step();
    end
    rd_req = 1'b0;
    check("t3_done_seen", done_seen, 1);
    check("t3_turn_r_cycles", turn_r, 1);
    check("t3_strobes", strobes, 16);
    for (int w = 0; w < 16; w++) check($sformatf("t3_data%0d", w), rd_log[w], w + 1);
    check("t3_done_at_strobe", done_at, 16);
    check("t3_done_with_valid", done_valid, 1'b1);
    check("t3_write_at_done", done_write, 1'b1);
    step(); step();
    check("t3_write_after2", icap_write, 1'b0);
    check("t3_ce_after2", icap_ce, 1'b1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rd_valid || rd_done || icap_write || !icap_ce) bad++;
    end
    check("t3_no_second_read", bad, 0);
    check("t3_rptr_final", rptr, 8'd16);

    // 4: zero-length readback
    rd_req = 1'b1; rd_len = 16'd0;
    step();
    rd_req = 1'b0;
    check("t4_done", rd_done, 1'b1);
    check("t4_ce", icap_ce, 1'b1);
    check("t4_write", icap_write, 1'b0);
    step();
    check("t4_done_clear", rd_done, 1'b0);
    check("t4_ce_after", icap_ce, 1'b1);
    check("t4_valid", rd_valid, 1'b0);

    // 5: rd_req and wr_valid together, write goes first
    model_clear();
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; rd_req = 1'b1; rd_len = 16'd1;
    #1;
    check("t5_ready", wr_ready, 1'b1);
    @(posedge CLK); #1;
    wr_valid = 1'b0; rd_req = 1'b0;
    check("t5_ce_loaded", icap_ce, 1'b0);
    check("t5_i_loaded", icap_i, exp_w(32'hDEAD_BEEF));
    check("t5_ctrl_busy", ctrl_busy, 1'b1);
    check("t5_ready_pend", wr_ready, 1'b0);
    step();
    check("t5_accept_wptr", wptr, 8'd1);
    check("t5_ce_after_accept", icap_ce, 1'b1);
    check("t5_write_after_accept", icap_write, 1'b0);
    step();
    check("t5_turn_r_write", icap_write, 1'b1);
    check("t5_turn_r_ce", icap_ce, 1'b1);
    step();
    check("t5_read_ce", icap_ce, 1'b0);
    step();
    check("t5_rptr", rptr, 8'd1);
    step();
    check("t5_rd_valid", rd_valid, 1'b1);
    check("t5_rd_data", rd_data, 32'hDEAD_BEEF);
    check("t5_rd_done", rd_done, 1'b1);
    check("t5_mem", mem[0], exp_w(32'hDEAD_BEEF));
    step(); step(); step();

    // 6: reset in the middle of an 8-word readback
    model_clear();
    rd_req = 1'b1; rd_len = 16'd8;
    step();
    rd_req = 1'b0;
    for (int c = 0; c < 40 && rptr != 8'd3; c++) step();
    check("t6_reached_3", rptr, 8'd3);
    RESET = 1'b1;
    #1;
    check("t6_ce", icap_ce, 1'b1);
    check("t6_write", icap_write, 1'b0);
    check("t6_rd_valid", rd_valid, 1'b0);
    check("t6_rd_done", rd_done, 1'b0);
    check("t6_ctrl_busy", ctrl_busy, 1'b0);
    check("t6_wr_ready", wr_ready, 1'b0);
    step(); step();
    RESET = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (rd_valid || rd_done || !icap_ce || icap_write) bad++;
    end
    check("t6_quiet_after_reset", bad, 0);
    check("t6_rptr_frozen", rptr, 8'd3);

`ifdef ICAP_BITSWAP_EN
    model_clear();
    wr_valid = 1'b1; wr_data = 32'h0102_0304;
    step();
    wr_valid = 1'b0;
    step();
    check("swap_mem", mem[0], 32'h8040_C020);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
